// File: rtl/instruction_decode.sv
// Purpose: MIPS ID stage, decodes R/I/J instructions into the ID/EX register.
// Latency: 1 cycle from d_i_instr/d_i_pc/d_i_ce to the d_o_* outputs.
// Backpressure: d_i_stall holds every output; d_i_flush (wins over stall) turns the slot into a bubble.
module instruction_decode #(
  parameter int IWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input  logic              d_clk,
  input  logic              d_rst,
  input  logic              d_i_ce,
  input  logic [IWIDTH-1:0] d_i_instr,
  input  logic [AWIDTH-1:0] d_i_pc,
  input  logic              d_i_stall,
  input  logic              d_i_flush,
  output logic              d_o_ce,
  output logic [AWIDTH-1:0] d_o_pc,
  output logic [RWIDTH-1:0] d_o_rs_addr,
  output logic [RWIDTH-1:0] d_o_rt_addr,
  output logic [RWIDTH-1:0] d_o_rd_addr,
  output logic [4:0]        d_o_shamt,
  output logic [31:0]       d_o_imm,
  output logic [3:0]        d_o_alu_op,
  output logic              d_o_alu_src,
  output logic              d_o_reg_write,
  output logic              d_o_mem_read,
  output logic              d_o_mem_write,
  output logic [1:0]        d_o_branch,
  output logic [1:0]        d_o_jump,
  output logic [AWIDTH-1:0] d_o_target,
  output logic              d_o_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // ID/EX register contents, kept as one bundle so hold/bubble/reset act on it uniformly
  typedef struct packed {
    logic              ce;
    logic [AWIDTH-1:0] pc;
    logic [RWIDTH-1:0] rs_addr;
    logic [RWIDTH-1:0] rt_addr;
    logic [RWIDTH-1:0] rd_addr;
    logic [4:0]        shamt;
    logic [31:0]       imm;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        branch;
    logic [1:0]        jump;
    logic [AWIDTH-1:0] target;
    logic              illegal;
  } id_ex_t;

  id_ex_t dec;
  id_ex_t id_ex_q;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [31:0]       imm_sext;
  logic [AWIDTH-1:0] pc_plus4;
  logic [AWIDTH-1:0] br_target;
  logic [AWIDTH-1:0] j_target;
  logic [4:0]        dest;
  logic              wr;
  logic              legal;

  assign opcode    = d_i_instr[31:26];
  assign funct     = d_i_instr[5:0];
  assign imm_sext  = {{16{d_i_instr[15]}}, d_i_instr[15:0]};
  assign pc_plus4  = d_i_pc + AWIDTH'(4);
  // Branch offset is a word count; wrap-around past the top of the address space is allowed
  assign br_target = pc_plus4 + AWIDTH'({imm_sext[29:0], 2'b00});
  assign j_target  = {pc_plus4[AWIDTH-1:28], d_i_instr[25:0], 2'b00};

  // Combinational decode of the incoming instruction into the next ID/EX bundle
  always_comb begin
    dec         = '0;
    dest        = d_i_instr[20:16];
    wr          = 1'b0;
    legal       = 1'b1;
    dec.ce      = d_i_ce;
    dec.pc      = d_i_pc;
    dec.rs_addr = RWIDTH'(d_i_instr[25:21]);
    dec.rt_addr = RWIDTH'(d_i_instr[20:16]);
    dec.shamt   = d_i_instr[10:6];
    dec.imm     = imm_sext;

    case (opcode)
      6'h00: begin
        dest = d_i_instr[15:11];
        wr   = 1'b1;
        case (funct)
          6'h20, 6'h21: dec.alu_op = ALU_ADD;
          6'h22, 6'h23: dec.alu_op = ALU_SUB;
          6'h24:        dec.alu_op = ALU_AND;
          6'h25:        dec.alu_op = ALU_OR;
          6'h26:        dec.alu_op = ALU_XOR;
          6'h27:        dec.alu_op = ALU_NOR;
          6'h2A:        dec.alu_op = ALU_SLT;
          6'h2B:        dec.alu_op = ALU_SLTU;
          6'h00:        dec.alu_op = ALU_SLL;
          6'h02:        dec.alu_op = ALU_SRL;
          6'h03:        dec.alu_op = ALU_SRA;
          6'h08: begin
            dec.jump = 2'b10;
            wr       = 1'b0;
          end
          default:      legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec.alu_op = ALU_ADD;  dec.alu_src = 1'b1; wr = 1'b1; end
      6'h0C: begin dec.alu_op = ALU_AND;  dec.alu_src = 1'b1; wr = 1'b1; dec.imm = {16'h0, d_i_instr[15:0]}; end
      6'h0D: begin dec.alu_op = ALU_OR;   dec.alu_src = 1'b1; wr = 1'b1; dec.imm = {16'h0, d_i_instr[15:0]}; end
      6'h0E: begin dec.alu_op = ALU_XOR;  dec.alu_src = 1'b1; wr = 1'b1; dec.imm = {16'h0, d_i_instr[15:0]}; end
      6'h0A: begin dec.alu_op = ALU_SLT;  dec.alu_src = 1'b1; wr = 1'b1; end
      6'h0B: begin dec.alu_op = ALU_SLTU; dec.alu_src = 1'b1; wr = 1'b1; end
      6'h0F: begin dec.alu_op = ALU_LUI;  dec.alu_src = 1'b1; wr = 1'b1; end
      6'h23: begin dec.alu_op = ALU_ADD;  dec.alu_src = 1'b1; wr = 1'b1; dec.mem_read = 1'b1; end
      6'h2B: begin dec.alu_op = ALU_ADD;  dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
      6'h04: begin dec.alu_op = ALU_SUB;  dec.branch = 2'b01; end
      6'h05: begin dec.alu_op = ALU_SUB;  dec.branch = 2'b10; end
      6'h02: begin dec.jump = 2'b01; dest = 5'd0; end
      6'h03: begin dec.jump = 2'b01; dest = 5'd31; wr = 1'b1; end
      default: legal = 1'b0;
    endcase

    // An unrecognised encoding must not leave any partial control behind
    if (!legal) begin
      dec.alu_op    = ALU_ADD;
      dec.alu_src   = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 2'b00;
      dec.jump      = 2'b00;
      dec.illegal   = 1'b1;
      wr            = 1'b0;
    end

    if (dec.branch != 2'b00) begin
      dec.target = br_target;
    end else if (dec.jump == 2'b01) begin
      dec.target = j_target;
    end

    // Writes to r0 are dropped here so sll r0,r0,0 needs no special casing downstream
    dec.rd_addr   = RWIDTH'(dest);
    dec.reg_write = wr && (dest != 5'd0);

    // A slot without a valid instruction must carry no side effects
    if (!d_i_ce) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 2'b00;
      dec.jump      = 2'b00;
      dec.illegal   = 1'b0;
    end
  end

  // ID/EX register: reset, then bubble, then hold, then load
  always_ff @(posedge d_clk) begin
    if (!d_rst) begin
      id_ex_q <= '0;
    end else if (d_i_flush) begin
      id_ex_q.ce        <= 1'b0;
      id_ex_q.reg_write <= 1'b0;
      id_ex_q.mem_read  <= 1'b0;
      id_ex_q.mem_write <= 1'b0;
      id_ex_q.branch    <= 2'b00;
      id_ex_q.jump      <= 2'b00;
      id_ex_q.illegal   <= 1'b0;
    end else if (!d_i_stall) begin
      id_ex_q <= dec;
    end
  end

  assign d_o_ce        = id_ex_q.ce;
  assign d_o_pc        = id_ex_q.pc;
  assign d_o_rs_addr   = id_ex_q.rs_addr;
  assign d_o_rt_addr   = id_ex_q.rt_addr;
  assign d_o_rd_addr   = id_ex_q.rd_addr;
  assign d_o_shamt     = id_ex_q.shamt;
  assign d_o_imm       = id_ex_q.imm;
  assign d_o_alu_op    = id_ex_q.alu_op;
  assign d_o_alu_src   = id_ex_q.alu_src;
  assign d_o_reg_write = id_ex_q.reg_write;
  assign d_o_mem_read  = id_ex_q.mem_read;
  assign d_o_mem_write = id_ex_q.mem_write;
  assign d_o_branch    = id_ex_q.branch;
  assign d_o_jump      = id_ex_q.jump;
  assign d_o_target    = id_ex_q.target;
  assign d_o_illegal   = id_ex_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Purpose: bench for instruction_decode, directed plan steps followed by randomized traffic.
// Latency: outputs compared 1 time unit after each rising edge against a reference model.
// Backpressure: stall/flush/reset driven directly and tracked by the model.
module tb_instruction_decode;

  logic        d_clk = 1'b0;
  logic        d_rst = 1'b0;
  logic        d_i_ce = 1'b0;
  logic [31:0] d_i_instr = '0;
  logic [31:0] d_i_pc = '0;
  logic        d_i_stall = 1'b0;
  logic        d_i_flush = 1'b0;
  logic        d_o_ce;
  logic [31:0] d_o_pc;
  logic [4:0]  d_o_rs_addr, d_o_rt_addr, d_o_rd_addr, d_o_shamt;
  logic [31:0] d_o_imm;
  logic [3:0]  d_o_alu_op;
  logic        d_o_alu_src, d_o_reg_write, d_o_mem_read, d_o_mem_write;
  logic [1:0]  d_o_branch, d_o_jump;
  logic [31:0] d_o_target;
  logic        d_o_illegal;

  int checks = 0;
  int errors = 0;

  instruction_decode dut (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_ce(d_i_ce), .d_i_instr(d_i_instr), .d_i_pc(d_i_pc),
    .d_i_stall(d_i_stall), .d_i_flush(d_i_flush), .d_o_ce(d_o_ce), .d_o_pc(d_o_pc),
    .d_o_rs_addr(d_o_rs_addr), .d_o_rt_addr(d_o_rt_addr), .d_o_rd_addr(d_o_rd_addr),
    .d_o_shamt(d_o_shamt), .d_o_imm(d_o_imm), .d_o_alu_op(d_o_alu_op), .d_o_alu_src(d_o_alu_src),
    .d_o_reg_write(d_o_reg_write), .d_o_mem_read(d_o_mem_read), .d_o_mem_write(d_o_mem_write),
    .d_o_branch(d_o_branch), .d_o_jump(d_o_jump), .d_o_target(d_o_target), .d_o_illegal(d_o_illegal)
  );

  always #5 d_clk = ~d_clk;

  typedef struct {
    bit        ce;
    bit [31:0] pc;
    int        rs, rt, rd, shamt;
    bit [31:0] imm;
    int        alu_op;
    bit        alu_src, reg_write, mem_read, mem_write;
    int        branch, jump;
    bit [31:0] target;
    bit        illegal;
  } exp_t;

  exp_t exp_q;
  bit   data_known;   // data fields are undefined after a bubble
  bit   rd_known;     // j and illegal encodings leave the destination unspecified

  // Reference: what an instruction means architecturally, derived field by field
  function automatic exp_t model(input bit [31:0] ins, input bit [31:0] pc, input bit ce,
                                 output bit rd_def);
    exp_t e;
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    bit [31:0] simm = {{16{ins[15]}}, ins[15:0]};
    bit [31:0] pc4 = pc + 32'd4;
    int  dest = int'(ins[20:16]);
    bit  writes = 0;
    bit  legal = 1;
    e = '{default: 0};
    e.ce = ce; e.pc = pc; e.rs = int'(ins[25:21]); e.rt = int'(ins[20:16]);
    e.shamt = int'(ins[10:6]); e.imm = simm;
    rd_def = 1;
    if (op == 0) begin
      dest = int'(ins[15:11]);
      writes = 1;
      case (fn)
        'h20, 'h21: e.alu_op = 0;
        'h22, 'h23: e.alu_op = 1;
        'h24: e.alu_op = 2;
        'h25: e.alu_op = 3;
        'h26: e.alu_op = 4;
        'h27: e.alu_op = 5;
        'h2A: e.alu_op = 6;
        'h2B: e.alu_op = 7;
        'h00: e.alu_op = 8;
        'h02: e.alu_op = 9;
        'h03: e.alu_op = 10;
        'h08: begin e.jump = 2; writes = 0; end
        default: legal = 0;
      endcase
    end else begin
      e.alu_src = 1;
      writes = 1;
      case (op)
        'h08, 'h09: e.alu_op = 0;
        'h0C: e.alu_op = 2;
        'h0D: e.alu_op = 3;
        'h0E: e.alu_op = 4;
        'h0A: e.alu_op = 6;
        'h0B: e.alu_op = 7;
        'h0F: e.alu_op = 11;
        'h23: e.mem_read = 1;
        'h2B: begin e.mem_write = 1; writes = 0; end
        'h04: begin e.alu_op = 1; e.branch = 1; writes = 0; e.alu_src = 0; end
        'h05: begin e.alu_op = 1; e.branch = 2; writes = 0; e.alu_src = 0; end
        'h02: begin e.jump = 1; writes = 0; e.alu_src = 0; rd_def = 0; end
        'h03: begin e.jump = 1; dest = 31; e.alu_src = 0; end
        default: legal = 0;
      endcase
      if (op == 'h0C || op == 'h0D || op == 'h0E) e.imm = simm & 32'h0000FFFF;
    end
    if (!legal) begin
      e.alu_op = 0; e.alu_src = 0; e.mem_read = 0; e.mem_write = 0;
      e.branch = 0; e.jump = 0; e.illegal = 1; writes = 0; rd_def = 0;
    end
    if (e.branch != 0) e.target = pc4 + (simm * 4);
    else if (e.jump == 1) e.target = (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    e.rd = dest;
    e.reg_write = writes && dest != 0;
    if (!ce) begin
      e.reg_write = 0; e.mem_read = 0; e.mem_write = 0;
      e.branch = 0; e.jump = 0; e.illegal = 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".ce"},        32'(d_o_ce),        32'(exp_q.ce));
    chk({ctx, ".reg_write"}, 32'(d_o_reg_write), 32'(exp_q.reg_write));
    chk({ctx, ".mem_read"},  32'(d_o_mem_read),  32'(exp_q.mem_read));
    chk({ctx, ".mem_write"}, 32'(d_o_mem_write), 32'(exp_q.mem_write));
    chk({ctx, ".branch"},    32'(d_o_branch),    32'(exp_q.branch));
    chk({ctx, ".jump"},      32'(d_o_jump),      32'(exp_q.jump));
    chk({ctx, ".illegal"},   32'(d_o_illegal),   32'(exp_q.illegal));
    if (data_known) begin
      chk({ctx, ".pc"},      d_o_pc,             exp_q.pc);
      chk({ctx, ".rs"},      32'(d_o_rs_addr),   32'(exp_q.rs));
      chk({ctx, ".rt"},      32'(d_o_rt_addr),   32'(exp_q.rt));
      chk({ctx, ".shamt"},   32'(d_o_shamt),     32'(exp_q.shamt));
      chk({ctx, ".imm"},     d_o_imm,            exp_q.imm);
      chk({ctx, ".alu_op"},  32'(d_o_alu_op),    32'(exp_q.alu_op));
      chk({ctx, ".alu_src"}, 32'(d_o_alu_src),   32'(exp_q.alu_src));
      chk({ctx, ".target"},  d_o_target,         exp_q.target);
      if (rd_known) chk({ctx, ".rd"}, 32'(d_o_rd_addr), 32'(exp_q.rd));
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, compare just after
  task automatic step(input string ctx, input bit rst_n, input bit ce, input bit [31:0] ins,
                      input bit [31:0] pc, input bit stall, input bit flush);
    bit rdd;
    exp_t nxt;
    @(negedge d_clk);
    d_rst = rst_n; d_i_ce = ce; d_i_instr = ins; d_i_pc = pc;
    d_i_stall = stall; d_i_flush = flush;
    @(posedge d_clk);
    if (!rst_n) begin
      exp_q = '{default: 0}; data_known = 1; rd_known = 1;
    end else if (flush) begin
      exp_q.ce = 0; exp_q.reg_write = 0; exp_q.mem_read = 0; exp_q.mem_write = 0;
      exp_q.branch = 0; exp_q.jump = 0; exp_q.illegal = 0; data_known = 0;
    end else if (!stall) begin
      nxt = model(ins, pc, ce, rdd);
      exp_q = nxt; data_known = 1; rd_known = rdd;
    end
    #1;
    check_all(ctx);
  endtask

  initial begin
    bit [31:0] ins, pc;
    bit ce, stall, flush, rst_n;
    int ops[15] = '{'h00, 'h08, 'h09, 'h0C, 'h0D, 'h0E, 'h0A, 'h0B, 'h0F, 'h23, 'h2B, 'h04, 'h05, 'h02, 'h03};
    int fns[12] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h00, 'h08};
    exp_q = '{default: 0}; data_known = 0; rd_known = 0;

    // Reset held for two cycles while a valid instruction is presented
    step("rst0", 0, 1, 32'h00221820, 32'h100, 0, 0);
    step("rst1", 0, 1, 32'h00221820, 32'h100, 0, 0);
    chk("rst.ce_zero", 32'(d_o_ce), 32'h0);
    chk("rst.target_zero", d_o_target, 32'h0);

    // add $3,$1,$2
    step("add", 1, 1, 32'h00221820, 32'h100, 0, 0);
    chk("add.rs", 32'(d_o_rs_addr), 32'd1);
    chk("add.rt", 32'(d_o_rt_addr), 32'd2);
    chk("add.rd", 32'(d_o_rd_addr), 32'd3);
    chk("add.alu_op", 32'(d_o_alu_op), 32'd0);
    chk("add.alu_src", 32'(d_o_alu_src), 32'd0);
    chk("add.reg_write", 32'(d_o_reg_write), 32'd1);
    chk("add.pc", d_o_pc, 32'h100);
    chk("add.ce", 32'(d_o_ce), 32'd1);

    // addi $5,$4,-1 and ori $6,$6,0x8000
    step("addi", 1, 1, 32'h2085FFFF, 32'h104, 0, 0);
    chk("addi.imm", d_o_imm, 32'hFFFF_FFFF);
    chk("addi.rd", 32'(d_o_rd_addr), 32'd5);
    chk("addi.alu_src", 32'(d_o_alu_src), 32'd1);
    step("ori", 1, 1, 32'h34C68000, 32'h108, 0, 0);
    chk("ori.imm", d_o_imm, 32'h0000_8000);
    chk("ori.alu_op", 32'(d_o_alu_op), 32'd3);

    // beq $1,$2,+4 and jal 0x100
    step("beq", 1, 1, 32'h10220004, 32'h100, 0, 0);
    chk("beq.branch", 32'(d_o_branch), 32'd1);
    chk("beq.target", d_o_target, 32'h114);
    chk("beq.reg_write", 32'(d_o_reg_write), 32'd0);
    step("jal", 1, 1, 32'h0C000040, 32'h0040_0000, 0, 0);
    chk("jal.jump", 32'(d_o_jump), 32'd1);
    chk("jal.rd", 32'(d_o_rd_addr), 32'd31);
    chk("jal.target", d_o_target, 32'h100);
    chk("jal.reg_write", 32'(d_o_reg_write), 32'd1);

    // lw, then three stalled cycles with different inputs presented
    step("lw", 1, 1, 32'h8C230010, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 1, 32'h00221820, 32'h300 + 32'(4 * i), 1, 0);
      chk("stall.mem_read", 32'(d_o_mem_read), 32'd1);
      chk("stall.pc", d_o_pc, 32'h200);
    end
    step("stall_flush", 1, 1, 32'h00221820, 32'h400, 1, 1);
    chk("sf.ce", 32'(d_o_ce), 32'd0);
    chk("sf.mem_read", 32'(d_o_mem_read), 32'd0);
    step("resume", 1, 1, 32'h00221820, 32'h404, 0, 0);
    chk("resume.pc", d_o_pc, 32'h404);
    chk("resume.ce", 32'(d_o_ce), 32'd1);

    // Illegal opcode and the all-zero NOP
    step("illegal", 1, 1, 32'hFC000000, 32'h500, 0, 0);
    chk("illegal.flag", 32'(d_o_illegal), 32'd1);
    chk("illegal.reg_write", 32'(d_o_reg_write), 32'd0);
    chk("illegal.ce", 32'(d_o_ce), 32'd1);
    step("nop", 1, 1, 32'h00000000, 32'h504, 0, 0);
    chk("nop.illegal", 32'(d_o_illegal), 32'd0);
    chk("nop.reg_write", 32'(d_o_reg_write), 32'd0);

    // Branch target wrap-around and mid-stream reset
    step("beq_wrap", 1, 1, 32'h10220010, 32'hFFFF_FFF0, 0, 0);
    chk("wrap.target", d_o_target, 32'h0000_0034);
    step("rst_mid", 0, 1, 32'h8C230010, 32'h600, 0, 0);
    chk("rst_mid.mem_read", 32'(d_o_mem_read), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        ins = $urandom;
      end else begin
        ins = $urandom;
        ins[31:26] = 6'(ops[$urandom_range(0, 14)]);
        if (ins[31:26] == 6'h00) ins[5:0] = 6'(fns[$urandom_range(0, 11)]);
      end
      pc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hFC)) : ($urandom & ~32'h3);
      ce    = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      step("rand", rst_n, ce, ins, pc, stall, flush);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage directly downstream of the instruction fetch stage in the 5-stage MIPS pipeline.
- Accepts the fetched instruction word, its PC and the fetch clock-enable.
- Decodes R/I/J formats into register addresses, an extended immediate, an ALU opcode, control strobes and branch/jump targets.
- Registers everything into the ID/EX boundary, with stall (hold) and flush (bubble) control from hazard logic.

Parameters:
- IWIDTH, 32, instruction word width.
- AWIDTH, 32, PC/address width.
- RWIDTH, 5, register-file address width.

Ports:
- d_clk  in  1  clock; all state updates on rising edge.
- d_rst  in  1  synchronous, active-low reset.
- d_i_ce  in  1  instruction valid from fetch (driven by f_o_ce).
- d_i_instr  in  IWIDTH  instruction word (driven by f_o_instr).
- d_i_pc  in  AWIDTH  PC of d_i_instr.
- d_i_stall  in  1  hold all outputs.
- d_i_flush  in  1  insert bubble.
- d_o_ce  out  1  decoded instruction valid.
- d_o_pc  out  AWIDTH  registered PC.
- d_o_rs_addr  out  RWIDTH  instr[25:21].
- d_o_rt_addr  out  RWIDTH  instr[20:16].
- d_o_rd_addr  out  RWIDTH  destination register.
- d_o_shamt  out  5  instr[10:6].
- d_o_imm  out  32  extended immediate.
- d_o_alu_op  out  4  ALU operation code.
- d_o_alu_src  out  1  1 = second operand is the immediate.
- d_o_reg_write  out  1  register write enable.
- d_o_mem_read  out  1  load.
- d_o_mem_write  out  1  store.
- d_o_branch  out  2  branch type: 00 none, 01 beq, 10 bne.
- d_o_jump  out  2  jump type: 00 none, 01 j/jal, 10 jr.
- d_o_target  out  AWIDTH  branch/jump target.
- d_o_illegal  out  1  unrecognised opcode/funct.

Behaviour:
- Register update priority per edge: reset > flush > stall > load.
- Reset (d_rst=0 at edge): every output goes to 0. Takes effect mid-stream and discards the in-flight instruction.
- Flush: d_o_ce=0 and all control outputs 0 (reg_write, mem_*, branch, jump, illegal). Data fields may take any value. Flush overrides stall in the same cycle.
- Stall (flush=0): every output register holds its value.
- Load (no stall/flush): outputs take the decode of the inputs; d_o_ce=d_i_ce. Latency is exactly 1 cycle.
- If d_i_ce=0, d_o_ce=0 and all control outputs are 0, so no side effects occur.
- ALU op encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11.
- R-type (opcode 0x00), by funct:
  - 20/21 ADD; 22/23 SUB; 24 AND; 25 OR; 26 XOR; 27 NOR; 2A SLT; 2B SLTU; 00 SLL; 02 SRL; 03 SRA.
  - 08 jr: jump=10, reg_write=0.
  - Destination is rd.
- I-type, by opcode:
  - 08/09 ADD; 0C AND; 0D OR; 0E XOR; 0A SLT; 0B SLTU; 0F LUI.
  - 23 lw: ADD, mem_read=1.
  - 2B sw: ADD, mem_write=1, reg_write=0.
  - 04 beq: SUB, branch=01, reg_write=0.
  - 05 bne: SUB, branch=10, reg_write=0.
  - Destination is rt; alu_src=1 except beq/bne.
- J-type, by opcode:
  - 02 j: jump=01, reg_write=0.
  - 03 jal: jump=01, rd_addr=31, reg_write=1.
- Immediate: zero-extended for andi/ori/xori; sign-extended for all others.
- Target:
  - beq/bne: pc + 4 + (sign-extended imm << 2), modulo 2^AWIDTH (wrap-around allowed).
  - j/jal: {(pc+4)[31:28], instr[25:0], 2'b00}.
  - Otherwise 0.
- reg_write is forced to 0 whenever the destination is register 0, so 0x00000000 (sll r0) is a true NOP.
- Unknown opcode or R-type funct: illegal=1, all other controls 0, d_o_ce still follows d_i_ce.

Test Plan:
- Reset: d_rst=0 for 2 cycles, including while d_i_ce=1 with an instruction applied -> all outputs 0, including d_o_ce. After release, the first load appears 1 cycle later.
- R-type: add $3,$1,$2 (0x00221820), pc=0x100 -> next cycle rs=1, rt=2, rd=3, alu_op=0, alu_src=0, reg_write=1, d_o_pc=0x100, d_o_ce=1.
- Immediate extension:
  - addi $5,$4,-1 (0x2085FFFF) -> imm=0xFFFFFFFF, rd=5, alu_src=1.
  - ori $6,$6,0x8000 (0x34C68000) -> imm=0x00008000, alu_op=3.
- Branch/jump:
  - beq $1,$2,+4 (0x10220004), pc=0x100 -> branch=01, target=0x114, reg_write=0.
  - jal (0x0C000040), pc=0x00400000 -> jump=01, rd=31, target=0x00000100, reg_write=1.
- Stall/flush: load lw, then stall 3 cycles -> outputs unchanged. Assert stall+flush together -> d_o_ce=0, mem_read=0. Deassert both -> the next instruction appears after 1 cycle.
- Illegal/NOP:
  - 0xFC000000 -> illegal=1, reg_write=0, d_o_ce=1.
  - 0x00000000 -> illegal=0, reg_write=0.
